// File: rtl/verifier_eval_h.sv
// Final-round sum-check verifier: evaluates H(0), H(1) and H(tau) from the prover's
// coefficients over F_q (q = 2^FNBits - 1) and checks H(0) + H(1) against the carried claim.
module verifier_eval_h #(
  parameter int unsigned nInputs = 16,
  parameter int unsigned FNBits  = 61,
  localparam int unsigned NBits  = $clog2(nInputs),
  localparam int unsigned IdxW   = $clog2(NBits + 1)
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       en,
  input  logic [FNBits-1:0]          tau,
  input  logic [FNBits-1:0]          claim_in,
  input  logic [NBits:0][FNBits-1:0] h_coeff_in,
  output logic [FNBits-1:0]          h0_out,
  output logic [FNBits-1:0]          h1_out,
  output logic [FNBits-1:0]          h_tau_out,
  output logic                       sum_ok,
  output logic                       ready,
  output logic                       ready_pulse
);

  // Modulus is the Mersenne prime 2^FNBits - 1; FNBits must be chosen so that it is prime.
  localparam logic [FNBits-1:0] Q = {FNBits{1'b1}};

  typedef enum logic [2:0] {StIdle, StSum, StHornInit, StHornMul, StHornAdd, StCheck} state_e;

  function automatic logic [FNBits-1:0] f_add(input logic [FNBits-1:0] a,
                                              input logic [FNBits-1:0] b);
    logic [FNBits:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[FNBits-1:0];
  endfunction

  // Mersenne fold: hi*2^n + lo == hi + lo (mod q); the folded sum stays below 2q.
  function automatic logic [FNBits-1:0] f_mul(input logic [FNBits-1:0] a,
                                              input logic [FNBits-1:0] b);
    logic [2*FNBits-1:0] p;
    logic [FNBits:0]     r;
    p = {{FNBits{1'b0}}, a} * {{FNBits{1'b0}}, b};
    r = {1'b0, p[FNBits-1:0]} + {1'b0, p[2*FNBits-1:FNBits]};
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    return r[FNBits-1:0];
  endfunction

  state_e                     state_q, state_d;
  logic [FNBits-1:0]          tau_q, tau_d;
  logic [FNBits-1:0]          claim_q, claim_d;
  logic [NBits:0][FNBits-1:0] coeff_q, coeff_d;
  logic [FNBits-1:0]          acc_s_q, acc_s_d;
  logic [FNBits-1:0]          acc_h_q, acc_h_d;
  logic [FNBits-1:0]          h0_q, h0_d;
  logic [IdxW-1:0]            k_q, k_d;
  logic [IdxW-1:0]            j_q, j_d;
  logic [FNBits-1:0]          h0_out_q, h0_out_d;
  logic [FNBits-1:0]          h1_out_q, h1_out_d;
  logic [FNBits-1:0]          h_tau_q, h_tau_d;
  logic                       sum_ok_q, sum_ok_d;

  // Shared field multiplier, single-cycle en-to-ready latency.
  logic                       mul_en;
  logic                       mul_ready_q;
  logic [FNBits-1:0]          mul_prod_q;

  always_ff @(posedge clk) begin
    if (rstb) begin
      mul_ready_q <= 1'b0;
      mul_prod_q  <= '0;
    end else begin
      mul_ready_q <= mul_en;
      if (mul_en) mul_prod_q <= f_mul(acc_h_q, tau_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    tau_d       = tau_q;
    claim_d     = claim_q;
    coeff_d     = coeff_q;
    acc_s_d     = acc_s_q;
    acc_h_d     = acc_h_q;
    h0_d        = h0_q;
    k_d         = k_q;
    j_d         = j_q;
    h0_out_d    = h0_out_q;
    h1_out_d    = h1_out_q;
    h_tau_d     = h_tau_q;
    sum_ok_d    = sum_ok_q;
    mul_en      = 1'b0;
    ready       = 1'b0;
    ready_pulse = 1'b0;

    unique case (state_q)
      StIdle: ready = 1'b1;
      StSum: begin
        acc_s_d = f_add(acc_s_q, coeff_q[k_q]);
        if (k_q == '0) h0_d = coeff_q[0];
        if (k_q == IdxW'(NBits)) state_d = StHornInit;
        else                     k_d = k_q + IdxW'(1);
      end
      StHornInit: begin
        acc_h_d = coeff_q[NBits];
        j_d     = IdxW'(NBits - 1);
        state_d = StHornMul;
      end
      StHornMul: begin
        mul_en  = 1'b1;
        state_d = StHornAdd;
      end
      StHornAdd: begin
        if (mul_ready_q) begin
          acc_h_d = f_add(mul_prod_q, coeff_q[j_q]);
          if (j_q == '0) begin
            state_d = StCheck;
          end else begin
            j_d     = j_q - IdxW'(1);
            state_d = StHornMul;
          end
        end
      end
      StCheck: begin
        ready       = 1'b1;
        ready_pulse = 1'b1;
        h0_out_d    = h0_q;
        h1_out_d    = acc_s_q;
        h_tau_d     = acc_h_q;
        sum_ok_d    = (f_add(h0_q, acc_s_q) == claim_q);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Completion cycle also accepts, so back-to-back runs have no gap.
    if (ready && en) begin
      tau_d   = tau;
      claim_d = claim_in;
      coeff_d = h_coeff_in;
      acc_s_d = '0;
      acc_h_d = '0;
      k_d     = '0;
      state_d = StSum;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q  <= StIdle;
      tau_q    <= '0;
      claim_q  <= '0;
      coeff_q  <= '0;
      acc_s_q  <= '0;
      acc_h_q  <= '0;
      h0_q     <= '0;
      k_q      <= '0;
      j_q      <= '0;
      h0_out_q <= '0;
      h1_out_q <= '0;
      h_tau_q  <= '0;
      sum_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tau_q    <= tau_d;
      claim_q  <= claim_d;
      coeff_q  <= coeff_d;
      acc_s_q  <= acc_s_d;
      acc_h_q  <= acc_h_d;
      h0_q     <= h0_d;
      k_q      <= k_d;
      j_q      <= j_d;
      h0_out_q <= h0_out_d;
      h1_out_q <= h1_out_d;
      h_tau_q  <= h_tau_d;
      sum_ok_q <= sum_ok_d;
    end
  end

  assign h0_out    = h0_out_q;
  assign h1_out    = h1_out_q;
  assign h_tau_out = h_tau_q;
  assign sum_ok    = sum_ok_q;

endmodule
